ram_block_reader: RTL
=====================

// Module: ram_block_reader
// PURPOSE
//  Drain-side consumer for the ping-pong sample buffer. It waits for the buffer-ready pulse,
//  then pulls exactly DEPTH samples over the buffer's read valid/ready interface.
//  Each sample is forwarded through a 2-entry output FIFO onto a framed stream (first/last tags).
//  It also reports the block's peak magnitude.
//  Sits between the ping-pong RAM and downstream DSP/serialiser stages.
// PARAMETERS
//  WIDTH       32              sample width, signed two's complement
//  DEPTH       16              samples per block (>=2)
//  CNT_WIDTH   $clog2(DEPTH+1) sample counter width
// PORTS
//  clk_i         in   1      clock
//  rst_ni        in   1      async active-low reset
//  buf_ready_i   in   1      1-cycle pulse: full block available
//  rd_data_i     in   WIDTH  signed sample from buffer
//  rd_valid_i    in   1      buffer read data valid
//  rd_ready_o    out  1      reader accepts sample this cycle
//  m_data_o      out  WIDTH  signed sample to downstream
//  m_valid_o     out  1      m_data_o valid
//  m_ready_i     in   1      downstream accepts
//  m_first_o     out  1      qualifies m_data_o: sample 0 of block
//  m_last_o      out  1      qualifies m_data_o: sample DEPTH-1 of block
//  peak_o        out  WIDTH  unsigned max |sample| of last completed block
//  peak_valid_o  out  1      1-cycle pulse: peak_o updated
//  busy_o        out  1      block in progress (state != IDLE)
//  overrun_o     out  1      1-cycle pulse: buf_ready_i while busy
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, FIFO empty, count=0, peak=0.
//   All outputs 0.
//  Handshakes: rd accept = rd_valid_i & rd_ready_o; m accept = m_valid_o & m_ready_i.
//   m_data_o/m_first_o/m_last_o hold stable while m_valid_o & !m_ready_i.
//  FSM:
//   IDLE:
//    - rd_ready_o=0.
//    - On buf_ready_i: go to DRAIN; clear count and peak accumulator.
//   DRAIN:
//    - rd_ready_o = (fifo_count<2); depends on registers only, no comb path from m_ready_i.
//    - Each rd accept pushes {data, first=(count==0), last=(count==DEPTH-1)}, then count++.
//    - On the accept with count==DEPTH-1 -> FLUSH.
//   FLUSH:
//    - rd_ready_o=0; wait until FIFO is empty.
//    - The cycle after the empty condition is seen -> DONE.
//   DONE (1 cycle):
//    - peak_o <= accumulator; peak_valid_o=1 -> IDLE.
//  Latency:
//   - Sample accepted at cycle N is on m_data_o at N+1 (FIFO output is registered).
//   - With m_ready_i held high, throughput is 1 sample/cycle.
//  Same-cycle push and pop on the FIFO: count unchanged. Order is strictly FIFO.
//  Magnitude: |x| computed in WIDTH bits unsigned; -2^(WIDTH-1) maps to 2^(WIDTH-1), no saturation.
//   Running max compares unsigned.
//  Overrun: buf_ready_i in DRAIN/FLUSH/DONE pulses overrun_o next cycle; the pulse is otherwise ignored.
//   The current block continues unaffected.
//  rd_valid_i low in DRAIN: stall, no count change. No timeout.
//  peak_o holds its value until the next DONE. busy_o=1 in DRAIN, FLUSH, DONE.
//  Reset mid-block: immediate abort. FIFO is flushed and the partial block is discarded.
// TESTING
//  1 Reset: rst_ni=0 mid-DRAIN
//    -> all outputs 0 asynchronously; IDLE after release; next buf_ready_i restarts at count 0.
//  2 Full rate: pulse, DEPTH=16, samples 0..15, rd_valid_i & m_ready_i =1
//    -> 16 beats, m_first_o on 0, m_last_o on 15, peak_o=15, peak_valid_o 3 cycles after last accept.
//  3 Backpressure: m_ready_i=0 for 5 cycles mid-block
//    -> rd_ready_o falls after 2 buffered, data stable, no loss/duplication, order preserved.
//  4 Magnitude: samples include -2^31, +2^31-1 -> peak_o=32'h8000_0000.
//  5 Overrun: second buf_ready_i at sample 7 -> overrun_o 1 pulse, block still 16 beats, one peak_valid_o.
//  6 Gaps: rd_valid_i toggled randomly, m_ready_i random -> output stream equals input order, count exact.

Source files
------------

// File: rtl/ram_block_reader.sv
// Drain-side reader for the ping-pong sample buffer: pulls one block of DEPTH samples,
// forwards them through a 2-entry registered FIFO as a framed stream and reports the block peak |x|.
module ram_block_reader #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             buf_ready_i,
  input  logic [WIDTH-1:0] rd_data_i,
  input  logic             rd_valid_i,
  output logic             rd_ready_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic             m_first_o,
  output logic             m_last_o,
  output logic [WIDTH-1:0] peak_o,
  output logic             peak_valid_o,
  output logic             busy_o,
  output logic             overrun_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]     r_peak;
  logic                 r_overrun;
  logic [1:0]           r_fcnt;
  logic [WIDTH-1:0]     r_head_d;
  logic                 r_head_f;
  logic                 r_head_l;
  logic [WIDTH-1:0]     r_tail_d;
  logic                 r_tail_f;
  logic                 r_tail_l;
  logic                 w_rd_acc;
  logic                 w_pop;
  logic                 w_in_first;
  logic                 w_in_last;
  logic [WIDTH-1:0]     w_mag;

  // Two's complement magnitude; the most negative value wraps to 2^(WIDTH-1) as an unsigned result.
  function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] x);
    if (x[WIDTH-1]) begin
      return (~x) + WIDTH'(1);
    end else begin
      return x;
    end
  endfunction

  assign w_rd_acc   = rd_valid_i & rd_ready_o;
  assign w_pop      = m_valid_o & m_ready_i;
  assign w_in_first = (r_cnt == CNT_WIDTH'(0));
  assign w_in_last  = (r_cnt == CNT_WIDTH'(DEPTH - 1));
  assign w_mag      = abs_mag(rd_data_i);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (buf_ready_i) w_next = S_DRAIN; else w_next = S_IDLE;
      S_DRAIN: if (w_rd_acc && w_in_last) w_next = S_FLUSH; else w_next = S_DRAIN;
      S_FLUSH: if (r_fcnt == 2'd0) w_next = S_DONE; else w_next = S_FLUSH;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM outputs; rd_ready_o depends only on registers so m_ready_i never reaches it combinationally
  always_comb begin
    rd_ready_o   = 1'b0;
    busy_o       = 1'b1;
    peak_valid_o = 1'b0;
    case (r_state)
      S_IDLE:  busy_o       = 1'b0;
      S_DRAIN: rd_ready_o   = (r_fcnt < 2'd2);
      S_FLUSH: rd_ready_o   = 1'b0;
      S_DONE:  peak_valid_o = 1'b1;
      default: busy_o       = 1'b0;
    endcase
  end

  // Sample counter, running peak and the published peak (loaded as DONE is entered)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_peak <= '0;
    end else begin
      if (r_state == S_IDLE && buf_ready_i) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else if (w_rd_acc) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
        if (w_mag > r_acc) r_acc <= w_mag;
      end
      if (r_state == S_FLUSH && r_fcnt == 2'd0) r_peak <= r_acc;
    end
  end

  // Overrun flag: a buffer-ready pulse arriving while a block is still in progress
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= buf_ready_i & (r_state != S_IDLE);
    end
  end

  // Output FIFO: head is the registered output stage, tail only fills while the head is stalled
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fcnt   <= 2'd0;
      r_head_d <= '0;
      r_head_f <= 1'b0;
      r_head_l <= 1'b0;
      r_tail_d <= '0;
      r_tail_f <= 1'b0;
      r_tail_l <= 1'b0;
    end else begin
      case (r_fcnt)
        2'd0: begin
          if (w_rd_acc) begin
            r_head_d <= rd_data_i;
            r_head_f <= w_in_first;
            r_head_l <= w_in_last;
            r_fcnt   <= 2'd1;
          end
        end
        2'd1: begin
          if (w_rd_acc && w_pop) begin
            r_head_d <= rd_data_i;
            r_head_f <= w_in_first;
            r_head_l <= w_in_last;
          end else if (w_rd_acc) begin
            r_tail_d <= rd_data_i;
            r_tail_f <= w_in_first;
            r_tail_l <= w_in_last;
            r_fcnt   <= 2'd2;
          end else if (w_pop) begin
            r_fcnt <= 2'd0;
          end
        end
        2'd2: begin
          if (w_pop) begin
            r_head_d <= r_tail_d;
            r_head_f <= r_tail_f;
            r_head_l <= r_tail_l;
            r_fcnt   <= 2'd1;
          end
        end
        default: r_fcnt <= 2'd0;
      endcase
    end
  end

  assign m_valid_o = (r_fcnt != 2'd0);
  assign m_data_o  = r_head_d;
  assign m_first_o = r_head_f;
  assign m_last_o  = r_head_l;
  assign peak_o    = r_peak;
  assign overrun_o = r_overrun;

endmodule
